fsk_bit_decoder: RTL and testbench
==================================

# fsk_bit_decoder

Downstream of the FSK frequency analyzer: slices the analyzer's three free-running tick accumulators (f0, f1, unknown) into fixed bit windows and turns each window into one decoded bit or an erasure. Each window's share is computed as a modulo-2^32 delta from a snapshot, so the analyzer is never cleared mid-stream. Decisions leave through a single-entry valid/ready output register toward the framing/UART stage.

## Interface
Parameters:
- WINDOW_TICKS, 5000: bit window length in clock ticks (10 kbaud at 50 MHz); used when window_ticks input is 0.
- MIN_DOMINANCE_PERCENT, 60: minimum share of (d0+d1) the winning tone needs.
- MAX_UNKNOWN_PERCENT, 25: maximum share of the window total allowed as unknown.

Ports:
- clock  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run decoder; low = idle.
- window_ticks  in  32  runtime window length; 0 selects WINDOW_TICKS; values 1–3 are forced to 4.
- f0_value  in  32  analyzer f0 accumulator.
- f1_value  in  32  analyzer f1 accumulator.
- unknown  in  32  analyzer unassigned accumulator.
- analyzer_enable  out  1  drives the analyzer's enable.
- bit_data  out  1  decoded bit (1 = f1 dominant).
- bit_erasure  out  1  window undecidable; bit_data = 0 when set.
- bit_valid  out  1  output register holds an unconsumed decision.
- bit_ready  in  1  consumer accepts when bit_valid & bit_ready.
- overrun  out  1  sticky: an unconsumed decision was overwritten.

## Operation
- States: IDLE, PRIME, RUN.
- IDLE: analyzer_enable = 0; window counter held at 0. enable=1 -> PRIME.
- PRIME (1 cycle): latch the effective window length as len; snapshot all three accumulators; clear overrun; analyzer_enable = 1; -> RUN.
- RUN: window counter counts 0..len-1 and wraps. At count = len-1 assert a terminal pulse (tc).
- On tc, stage 1: d0 = f0_value - snap0, d1 = f1_value - snap1, du = unknown - snapu (32-bit, mod 2^32). Register the deltas and reload the snapshots from the same inputs in the same cycle, so no ticks are lost or double-counted.
- Stage 2, classify with 40-bit products and tot = d0+d1+du as a 34-bit value:
  - tot = 0 -> erasure.
  - du*100 > tot*MAX_UNKNOWN_PERCENT -> erasure.
  - d1*100 >= (d0+d1)*MIN_DOMINANCE_PERCENT -> bit 1.
  - d0*100 >= (d0+d1)*MIN_DOMINANCE_PERCENT -> bit 0.
  - otherwise -> erasure.
- The classification result loads the output register.
- enable=0 in any state -> IDLE next cycle. The partial window and any in-flight pipeline stages are discarded. A decision already in the output register stays until consumed.
- window_ticks is sampled only in PRIME; changes while in RUN are ignored.

## Timing
- Reset values: analyzer_enable = 0, bit_data = 0, bit_erasure = 0, bit_valid = 0, overrun = 0. State = IDLE; all counters and snapshots = 0.
- Reset mid-operation clears everything at once; no decision is emitted.
- First tc occurs len cycles after PRIME. Subsequent tc pulses are exactly len cycles apart.
- Latency: bit_valid rises 2 cycles after tc (stage 1 + stage 2 registers).
- Handshake: bit_valid stays high with data stable until bit_valid & bit_ready; bit_valid falls the next cycle unless a new decision loads.
- Load in the same cycle as an accept: the new decision is loaded, bit_valid stays 1, overrun is not set.
- Load while bit_valid & !bit_ready: the new decision overwrites the old one and overrun sets. overrun clears only on reset or PRIME.
- Accumulator wrap is handled by the modular subtraction. A window delta above 2^32-1 is unsupported (len is 32-bit, so it cannot occur).
- The analyzer commits ticks only at signal edges, so a half-period spanning tc is credited to the later window. This is accepted behaviour.

## Structure
- Package fsk_pkg: state enum {IDLE, PRIME, RUN}, MIN_WINDOW = 4, PERCENT_SCALE = 100, and the decision encoding (bit, erasure).
- Sub-module fsk_window_classifier: the registered stage-2 compare. Inputs are d0, d1, du plus the two percent parameters; output is {bit, erasure}.
- Top level holds the FSM, window counter, snapshots, stage-1 registers and the output register.

## Test plan
- WINDOW_TICKS=100; per window, f1_value +90, f0_value +5, unknown +5 -> bit_valid 2 cycles after each tc with bit_data=1, bit_erasure=0.
- Per window, f0 +50, f1 +40, unknown +10 (dominance 55.6% < 60%) -> bit_erasure=1, bit_data=0.
- f0_value preset to 0xFFFF_FFF0 then incremented by 0x40 within one window, others flat -> d0=0x40, bit 0, no erasure.
- bit_ready held 0 over two windows -> second decision overwrites, overrun=1. Accept asserted in the same cycle as the third load -> bit_valid stays 1, overrun remains 1 until the next PRIME.
- enable dropped mid-window, then reasserted with window_ticks=2 -> effective len=4; tc every 4 cycles; overrun cleared; partial window never reported.
- reset asserted asynchronously while bit_valid=1 -> all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/fsk_pkg.sv
// Shared types and constants for the FSK bit decoder: FSM states, decision encoding
// and the window-length clamp applied when a run is primed.
package fsk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

   localparam int unsigned MIN_WINDOW    = 4;
   localparam int unsigned PERCENT_SCALE = 100;

   typedef struct packed {
      logic data;
      logic erasure;
   } decision_t;

   localparam decision_t DECISION_ERASURE = '{data: 1'b0, erasure: 1'b1};

   // A request of 0 selects the build-time default; tiny windows are clamped up.
   function automatic logic [31:0] effective_len(input logic [31:0] req,
                                                 input logic [31:0] dflt);
      if (req == 32'd0) begin
         return dflt;
      end else if (req < 32'(MIN_WINDOW)) begin
         return 32'(MIN_WINDOW);
      end else begin
         return req;
      end
   endfunction

endpackage

// File: rtl/fsk_window_classifier.sv
// Stage-2 compare: turns one window's tick deltas into a bit or an erasure. The result
// is captured by the decoder's output register, which is the stage-2 register.
module fsk_window_classifier
   import fsk_pkg::*;
#(
   parameter int unsigned MIN_DOMINANCE_PERCENT = 60,
   parameter int unsigned MAX_UNKNOWN_PERCENT   = 25
) (
   input  logic [31:0] d0_i,
   input  logic [31:0] d1_i,
   input  logic [31:0] du_i,
   output decision_t   decision_o
);

   logic [33:0] tot;
   logic [32:0] pair;
   logic [39:0] du_scaled;
   logic [39:0] tot_limit;
   logic [39:0] d0_scaled;
   logic [39:0] d1_scaled;
   logic [39:0] pair_limit;

   // Products are widened to 40 bits so full-scale 32-bit deltas cannot overflow.
   always_comb begin
      pair       = {1'b0, d0_i} + {1'b0, d1_i};
      tot        = {2'b00, d0_i} + {2'b00, d1_i} + {2'b00, du_i};
      du_scaled  = 40'(du_i) * 40'(PERCENT_SCALE);
      tot_limit  = 40'(tot) * 40'(MAX_UNKNOWN_PERCENT);
      d0_scaled  = 40'(d0_i) * 40'(PERCENT_SCALE);
      d1_scaled  = 40'(d1_i) * 40'(PERCENT_SCALE);
      pair_limit = 40'(pair) * 40'(MIN_DOMINANCE_PERCENT);
   end

   // NOTE: every output gets a default first so no latch is inferred on an untaken branch.
   always_comb begin
      decision_o = DECISION_ERASURE;
      if (tot == 34'd0 || du_scaled > tot_limit) begin
         decision_o = DECISION_ERASURE;
      end else if (d1_scaled >= pair_limit) begin
         decision_o = '{data: 1'b1, erasure: 1'b0};
      end else if (d0_scaled >= pair_limit) begin
         decision_o = '{data: 1'b0, erasure: 1'b0};
      end
   end

endmodule

// File: rtl/fsk_bit_decoder.sv
// Slices the analyzer's free-running accumulators into bit windows and emits one
// decision per window through a single-entry valid/ready register.
module fsk_bit_decoder
   import fsk_pkg::*;
#(
   parameter int unsigned WINDOW_TICKS          = 5000,
   parameter int unsigned MIN_DOMINANCE_PERCENT = 60,
   parameter int unsigned MAX_UNKNOWN_PERCENT   = 25
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic [31:0] window_ticks,
   input  logic [31:0] f0_value,
   input  logic [31:0] f1_value,
   input  logic [31:0] unknown,
   output logic        analyzer_enable,
   output logic        bit_data,
   output logic        bit_erasure,
   output logic        bit_valid,
   input  logic        bit_ready,
   output logic        overrun
);

   state_e      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [31:0] len_q, len_d;
   logic [31:0] snap0_q, snap0_d, snap1_q, snap1_d, snapu_q, snapu_d;
   logic [31:0] d0_q, d0_d, d1_q, d1_d, du_q, du_d;
   logic        s1_valid_q, s1_valid_d;
   decision_t   out_q, out_d;
   logic        valid_q, valid_d;
   logic        overrun_q, overrun_d;

   logic        tc;
   logic        load;
   decision_t   decision;

   assign tc   = (state_q == RUN) && (cnt_q == len_q - 32'd1);
   assign load = s1_valid_q && enable;

   fsk_window_classifier #(
      .MIN_DOMINANCE_PERCENT (MIN_DOMINANCE_PERCENT),
      .MAX_UNKNOWN_PERCENT   (MAX_UNKNOWN_PERCENT)
   ) u_classifier (
      .d0_i       (d0_q),
      .d1_i       (d1_q),
      .du_i       (du_q),
      .decision_o (decision)
   );

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      len_d      = len_q;
      snap0_d    = snap0_q;
      snap1_d    = snap1_q;
      snapu_d    = snapu_q;
      d0_d       = d0_q;
      d1_d       = d1_q;
      du_d       = du_q;
      s1_valid_d = 1'b0;
      out_d      = out_q;
      valid_d    = valid_q;
      overrun_d  = overrun_q;

      case (state_q)
         IDLE: begin
            cnt_d = 32'd0;
            if (enable) state_d = PRIME;
         end
         PRIME: begin
            cnt_d     = 32'd0;
            len_d     = effective_len(window_ticks, 32'(WINDOW_TICKS));
            snap0_d   = f0_value;
            snap1_d   = f1_value;
            snapu_d   = unknown;
            overrun_d = 1'b0;
            state_d   = enable ? RUN : IDLE;
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
               cnt_d   = 32'd0;
            end else if (tc) begin
               // Deltas and snapshot reload use the same sample, so no tick is lost.
               cnt_d      = 32'd0;
               d0_d       = f0_value - snap0_q;
               d1_d       = f1_value - snap1_q;
               du_d       = unknown - snapu_q;
               snap0_d    = f0_value;
               snap1_d    = f1_value;
               snapu_d    = unknown;
               s1_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         out_d   = decision;
         valid_d = 1'b1;
         if (valid_q && !bit_ready) overrun_d = 1'b1;
      end else if (valid_q && bit_ready) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= 32'd0;
         len_q      <= 32'd0;
         snap0_q    <= 32'd0;
         snap1_q    <= 32'd0;
         snapu_q    <= 32'd0;
         d0_q       <= 32'd0;
         d1_q       <= 32'd0;
         du_q       <= 32'd0;
         s1_valid_q <= 1'b0;
         out_q      <= '{data: 1'b0, erasure: 1'b0};
         valid_q    <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         len_q      <= len_d;
         snap0_q    <= snap0_d;
         snap1_q    <= snap1_d;
         snapu_q    <= snapu_d;
         d0_q       <= d0_d;
         d1_q       <= d1_d;
         du_q       <= du_d;
         s1_valid_q <= s1_valid_d;
         out_q      <= out_d;
         valid_q    <= valid_d;
         overrun_q  <= overrun_d;
      end
   end

   assign analyzer_enable = (state_q != IDLE);
   assign bit_data        = out_q.data;
   assign bit_erasure     = out_q.erasure;
   assign bit_valid       = valid_q;
   assign overrun         = overrun_q;

endmodule

// File: tb/tb_fsk_bit_decoder.sv
// Directed bench for fsk_bit_decoder: a table of per-window tick increments with
// hand-computed decisions, then overrun, enable-drop and async-reset sequences.
module tb_fsk_bit_decoder;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [31:0] window_ticks;
   logic [31:0] f0_value;
   logic [31:0] f1_value;
   logic [31:0] unknown;
   logic        analyzer_enable;
   logic        bit_data;
   logic        bit_erasure;
   logic        bit_valid;
   logic        bit_ready;
   logic        overrun;

   int n_checks = 0;
   int n_fail   = 0;

   fsk_bit_decoder #(
      .WINDOW_TICKS          (100),
      .MIN_DOMINANCE_PERCENT (60),
      .MAX_UNKNOWN_PERCENT   (25)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .enable          (enable),
      .window_ticks    (window_ticks),
      .f0_value        (f0_value),
      .f1_value        (f1_value),
      .unknown         (unknown),
      .analyzer_enable (analyzer_enable),
      .bit_data        (bit_data),
      .bit_erasure     (bit_erasure),
      .bit_valid       (bit_valid),
      .bit_ready       (bit_ready),
      .overrun         (overrun)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] inc0;
      logic [31:0] inc1;
      logic [31:0] incu;
      logic        exp_data;
      logic        exp_erasure;
   } vec_t;

   localparam int NVEC = 11;
   vec_t vecs[NVEC];

   function automatic vec_t mk(input logic [31:0] i0, input logic [31:0] i1,
                               input logic [31:0] iu, input logic ed, input logic ee);
      vec_t v;
      v.inc0 = i0; v.inc1 = i1; v.incu = iu; v.exp_data = ed; v.exp_erasure = ee;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic add(input logic [31:0] i0, input logic [31:0] i1, input logic [31:0] iu);
      f0_value = f0_value + i0;
      f1_value = f1_value + i1;
      unknown  = unknown + iu;
   endtask

   task automatic wait_valid(input int max_cycles, output int n);
      n = 0;
      while (bit_valid !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;

      vecs[0]  = mk(32'h40, 32'd0, 32'd0, 1'b0, 1'b0);                // f0 wraps past 2^32
      vecs[1]  = mk(32'd5, 32'd90, 32'd5, 1'b1, 1'b0);
      vecs[2]  = mk(32'd50, 32'd40, 32'd10, 1'b0, 1'b1);              // 55.6% dominance
      vecs[3]  = mk(32'd40, 32'd60, 32'd0, 1'b1, 1'b0);                // exactly 60% f1
      vecs[4]  = mk(32'd0, 32'd75, 32'd25, 1'b1, 1'b0);                // exactly 25% unknown
      vecs[5]  = mk(32'd0, 32'd74, 32'd26, 1'b0, 1'b1);                // 26% unknown
      vecs[6]  = mk(32'd59, 32'd41, 32'd0, 1'b0, 1'b1);
      vecs[7]  = mk(32'd60, 32'd40, 32'd0, 1'b0, 1'b0);                // exactly 60% f0
      vecs[8]  = mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);                  // empty window
      vecs[9]  = mk(32'h1000_0000, 32'h8000_0000, 32'd0, 1'b1, 1'b0);  // needs wide products
      vecs[10] = mk(32'd0, 32'd0, 32'd7, 1'b0, 1'b1);

      reset        = 1'b1;
      enable       = 1'b0;
      bit_ready    = 1'b0;
      window_ticks = 32'd0;
      f0_value     = 32'd0;
      f1_value     = 32'd0;
      unknown      = 32'd0;
      #1;
      check("rst analyzer_enable", analyzer_enable, 0);
      check("rst bit_data", bit_data, 0);
      check("rst bit_erasure", bit_erasure, 0);
      check("rst bit_valid", bit_valid, 0);
      check("rst overrun", overrun, 0);
      repeat (3) tick();
      reset = 1'b0;
      tick();
      check("idle analyzer_enable", analyzer_enable, 0);

      // Table: default window of 100, one decision per window, consumer always ready.
      f0_value  = 32'hFFFF_FFF0;
      bit_ready = 1'b1;
      enable    = 1'b1;
      tick();
      check("prime analyzer_enable", analyzer_enable, 1);
      tick();
      for (int i = 0; i < NVEC; i++) begin
         add(vecs[i].inc0, vecs[i].inc1, vecs[i].incu);
         wait_valid(300, n);
         check($sformatf("vec%0d latency", i), n, (i == 0) ? 101 : 99);
         check($sformatf("vec%0d bit_data", i), bit_data, vecs[i].exp_data);
         check($sformatf("vec%0d bit_erasure", i), bit_erasure, vecs[i].exp_erasure);
         check($sformatf("vec%0d overrun", i), overrun, 0);
         tick();
         check($sformatf("vec%0d accepted", i), bit_valid, 0);
      end

      // Overrun: two loads without a consumer, then accept coinciding with the third load.
      bit_ready = 1'b0;
      add(32'd20, 32'd80, 32'd0);
      wait_valid(300, n);
      check("ovr first latency", n, 99);
      check("ovr first bit_data", bit_data, 1);
      check("ovr first overrun", overrun, 0);
      add(32'd70, 32'd30, 32'd0);
      repeat (100) tick();
      check("ovr second valid", bit_valid, 1);
      check("ovr second bit_data", bit_data, 0);
      check("ovr second erasure", bit_erasure, 0);
      check("ovr second overrun", overrun, 1);
      add(32'd50, 32'd50, 32'd0);
      repeat (99) tick();
      bit_ready = 1'b1;
      tick();
      check("ovr third valid", bit_valid, 1);
      check("ovr third erasure", bit_erasure, 1);
      check("ovr third bit_data", bit_data, 0);
      check("ovr third overrun", overrun, 1);
      tick();
      check("ovr drained valid", bit_valid, 0);
      check("ovr sticky", overrun, 1);

      // Drop enable mid-window, restart with a clamped window of 4.
      add(32'd0, 32'd50, 32'd0);
      repeat (10) tick();
      enable = 1'b0;
      tick();
      check("drop analyzer_enable", analyzer_enable, 0);
      repeat (3) tick();
      check("drop no decision", bit_valid, 0);
      window_ticks = 32'd2;
      add(32'd0, 32'd3, 32'd0);
      enable = 1'b1;
      tick();
      check("restart prime overrun held", overrun, 1);
      tick();
      check("restart overrun cleared", overrun, 0);
      window_ticks = 32'd50;
      add(32'd1, 32'd9, 32'd0);
      wait_valid(20, n);
      check("len4 first latency", n, 5);
      check("len4 first bit_data", bit_data, 1);
      check("len4 first erasure", bit_erasure, 0);
      add(32'd9, 32'd1, 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         check($sformatf("len4 gap%0d", k), bit_valid, 0);
      end
      tick();
      check("len4 second valid", bit_valid, 1);
      check("len4 second bit_data", bit_data, 0);

      // Async reset while a decision is held.
      add(32'd0, 32'd8, 32'd0);
      bit_ready = 1'b0;
      repeat (4) tick();
      check("pre-reset valid", bit_valid, 1);
      check("pre-reset bit_data", bit_data, 1);
      check("pre-reset overrun", overrun, 1);
      #3;
      reset = 1'b1;
      #1;
      check("async rst bit_valid", bit_valid, 0);
      check("async rst bit_data", bit_data, 0);
      check("async rst bit_erasure", bit_erasure, 0);
      check("async rst overrun", overrun, 0);
      check("async rst analyzer_enable", analyzer_enable, 0);
      enable = 1'b0;
      tick();
      reset = 1'b0;
      repeat (3) tick();
      check("post-reset idle", analyzer_enable, 0);
      check("post-reset valid", bit_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
